// File: rtl/run_harness_pkg.sv
// run_harness_pkg
// Shared definitions for the run harness controller: the controller state
// encoding (also exported on the debug state port) and a width helper for
// the result-index bus.
package run_harness_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_READ  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Width of an index that must hold 0..words-1 with one bit of headroom.
  function automatic int idx_width(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/run_timer.sv
// run_timer
// Free-running up-counter with synchronous clear and enable, plus a
// terminal-count flag against a caller-supplied limit. The controller uses
// one instance for both the Start hold window and the RUN timeout.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   clr_i   clear the count to 0 on the next edge (dominates en_i)
//   en_i    increment the count on the next edge
//   term_i  terminal value compared against the current count
//   tc_o    count equals term_i while enabled
module run_timer #(
  parameter int TW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] term_i,
  output logic          tc_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/run_harness_ctrl.sv
// run_harness_ctrl
// Run controller that sits beside the processor core and owns one shared
// data-memory port. A run is: clear memory to zero, accept preload beats,
// pulse Start, wait for Ack (or time out), read back the result window.
//
// Ports:
//   Clk, Reset            clock (rising edge), asynchronous active-low reset
//   Go                    start a run; only sampled in IDLE and DONE
//   Ld_Valid/Ld_Ready     preload beat handshake
//   Ld_Addr/Ld_Data/Ld_Last  preload beat payload; Last ends the preload
//   Mem_WrEn/Mem_RdEn     registered memory strobes, never both high
//   Mem_Addr/Mem_WrData   registered memory address / write data
//   Mem_RdData            memory read data, valid one cycle after Mem_RdEn
//   Start                 core start, held START_HOLD cycles
//   Ack                   core done flag, honoured only in RUN
//   Res_Valid/Res_Idx/Res_Data  one strobe per result word
//   Busy, Done, Timeout   run status
//   Dbg_State             current controller state
module run_harness_ctrl
  import run_harness_pkg::*;
#(
  parameter int DW           = 8,
  parameter int AW           = 8,
  parameter int DEPTH        = 256,
  parameter int START_HOLD   = 2,
  parameter int TW           = 16,
  parameter int TIMEOUT      = 16'hFFFF,
  parameter int RESULT_BASE  = 5,
  parameter int RESULT_WORDS = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Go,
  input  logic                          Ld_Valid,
  output logic                          Ld_Ready,
  input  logic [AW-1:0]                 Ld_Addr,
  input  logic [DW-1:0]                 Ld_Data,
  input  logic                          Ld_Last,
  output logic                          Mem_WrEn,
  output logic                          Mem_RdEn,
  output logic [AW-1:0]                 Mem_Addr,
  output logic [DW-1:0]                 Mem_WrData,
  input  logic [DW-1:0]                 Mem_RdData,
  output logic                          Start,
  input  logic                          Ack,
  output logic                          Res_Valid,
  output logic [$clog2(RESULT_WORDS):0] Res_Idx,
  output logic [DW-1:0]                 Res_Data,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Timeout,
  output logic [STATE_W-1:0]            Dbg_State
);

  localparam int              IW         = idx_width(RESULT_WORDS);
  localparam logic [AW-1:0]   CLR_LAST   = AW'(DEPTH - 1);
  localparam logic [AW:0]     DEPTH_X    = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0]   HOLD_TC    = TW'(START_HOLD - 1);
  localparam logic [TW-1:0]   RUN_TC     = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0]   RES_BASE_A = AW'(RESULT_BASE);
  localparam logic [IW-1:0]   RES_LAST   = IW'(RESULT_WORDS - 1);

  state_e          state_q, state_d;
  logic            wren_q, wren_d;
  logic            rden_q, rden_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic            res_valid_q, res_valid_d;
  logic [IW-1:0]   res_idx_q, res_idx_d;
  logic [DW-1:0]   res_hold_q;

  logic            tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0]   tmr_term;

  run_timer #(.TW(TW)) u_timer (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

  // Preload handshake: a beat transfers on any rising edge where
  // Ld_Valid && Ld_Ready. Ld_Ready is high for the whole of LOAD, so the
  // producer alone sets the pace; Ld_Valid low simply stalls.
  assign Ld_Ready = (state_q == ST_LOAD);

  always_comb begin
    state_d     = state_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    start_d     = 1'b0;
    done_d      = done_q;
    timeout_d   = timeout_q;
    rd_idx_d    = rd_idx_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    tmr_clr     = 1'b1;
    tmr_en      = 1'b0;
    tmr_term    = RUN_TC;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Go) begin
          // The first clear write is issued together with the state change
          // so that memory strobes line up with the CLEAR cycles.
          state_d   = ST_CLEAR;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          wren_d    = 1'b1;
          addr_d    = '0;
          wdata_d   = '0;
        end
      end

      ST_CLEAR: begin
        // addr_q is the word being cleared this cycle.
        if (addr_q == CLR_LAST) begin
          state_d = ST_LOAD;
        end else begin
          wren_d  = 1'b1;
          addr_d  = addr_q + AW'(1);
          wdata_d = '0;
        end
      end

      ST_LOAD: begin
        if (Ld_Valid) begin
          // Out-of-range beats are consumed but never reach memory.
          wren_d  = ({1'b0, Ld_Addr} < DEPTH_X);
          addr_d  = Ld_Addr;
          wdata_d = Ld_Data;
          if (Ld_Last) begin
            state_d = ST_START;
            start_d = 1'b1;
          end
        end
      end

      ST_START: begin
        start_d  = 1'b1;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b1;
        tmr_term = HOLD_TC;
        if (tmr_tc) begin
          state_d = ST_RUN;
          start_d = 1'b0;
          tmr_clr = 1'b1;
        end
      end

      ST_RUN: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        // Ack is checked first so it wins over a simultaneous terminal count.
        if (Ack) begin
          state_d  = ST_READ;
          rden_d   = 1'b1;
          addr_d   = RES_BASE_A;
          rd_idx_d = '0;
          tmr_clr  = 1'b1;
        end else if (tmr_tc) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          tmr_clr   = 1'b1;
        end
      end

      ST_READ: begin
        // Result strobes trail the read strobes by one cycle; the cycle
        // with no read outstanding is the final result beat.
        res_valid_d = rden_q;
        res_idx_d   = rd_idx_q;
        if (rden_q) begin
          if (rd_idx_q != RES_LAST) begin
            rden_d   = 1'b1;
            addr_d   = addr_q + AW'(1);
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rd_idx_q    <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      rd_idx_q    <= rd_idx_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
    end
  end

  // Keeps the last delivered result word visible between strobes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      res_hold_q <= '0;
    end else if (res_valid_q) begin
      res_hold_q <= Mem_RdData;
    end
  end

  assign Mem_WrEn   = wren_q;
  assign Mem_RdEn   = rden_q;
  assign Mem_Addr   = addr_q;
  assign Mem_WrData = wdata_q;
  assign Start      = start_q;
  assign Res_Valid  = res_valid_q;
  assign Res_Idx    = res_idx_q;
  // Read data arrives in the strobe cycle, so it is passed straight through.
  assign Res_Data   = res_valid_q ? Mem_RdData : res_hold_q;
  assign Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign Done       = done_q;
  assign Timeout    = timeout_q;
  assign Dbg_State  = state_q;

endmodule

// File: doc/run_harness_ctrl.md
Name: run_harness_ctrl

Overview:
Synthesizable run controller that replaces the hand-driven simulation sequence around the processor top level: clear data memory, preload operands, pulse Start, wait for Ack, read back the result window. Sits beside the core and owns one shared data-memory port. Parametrised in data/address width, memory depth, start-hold length, result window and timeout. Adds a timeout/status path the manual sequence lacks.

Parameters:
DW, 8, data word width
AW, 8, memory address width
DEPTH, 256, words cleared in CLEAR (<= 2**AW)
START_HOLD, 2, cycles Start is held high before release
TW, 16, timeout counter width
TIMEOUT, 16'hFFFF, RUN cycles before abort
RESULT_BASE, 5, first result address
RESULT_WORDS, 4, result words read back (>= 1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Go  in  1  start a run, sampled in IDLE/DONE only
Ld_Valid  in  1  preload beat valid
Ld_Ready  out  1  preload beat accepted when Valid&Ready
Ld_Addr  in  AW  preload address
Ld_Data  in  DW  preload data
Ld_Last  in  1  final preload beat
Mem_WrEn  out  1  memory write strobe
Mem_RdEn  out  1  memory read strobe
Mem_Addr  out  AW  memory address
Mem_WrData  out  DW  memory write data
Mem_RdData  in  DW  read data, valid one cycle after Mem_RdEn
Start  out  1  core start; core runs after falling edge
Ack  in  1  core done flag
Res_Valid  out  1  result word strobe (one cycle)
Res_Idx  out  $clog2(RESULT_WORDS)+1  result index 0..RESULT_WORDS-1
Res_Data  out  DW  result word
Busy  out  1  high in every state except IDLE/DONE
Done  out  1  run finished (held in DONE)
Timeout  out  1  run aborted by timeout (held in DONE)

Behaviour:
- Reset asserted (low): state IDLE, every output 0, all counters 0; applies immediately mid-run, no completion of pending write/read.
- Mem_WrEn and Mem_RdEn never high together; Mem_* registered outputs.
- IDLE: Go=1 -> CLEAR next cycle. Go ignored in CLEAR..READ.
- CLEAR: one write of 0 per cycle, addr 0..DEPTH-1 ascending; DEPTH cycles, then LOAD.
- LOAD: Ld_Ready=1. Each accepted beat -> write Ld_Data at Ld_Addr next cycle. Ld_Addr >= DEPTH: beat accepted, no write. Accepted beat with Ld_Last=1 -> START. Ld_Valid low: wait indefinitely.
- START: Start=1 for exactly START_HOLD cycles, then RUN with Start=0. Ack ignored in START.
- RUN: timer counts from 0 each cycle. Ack=1 -> READ (Ack in same cycle as terminal count wins). Timer = TIMEOUT-1 without Ack -> DONE with Timeout=1.
- READ: issue Mem_RdEn at RESULT_BASE+i (mod 2**AW), i=0..RESULT_WORDS-1, one per cycle; Res_Valid/Res_Idx=i/Res_Data one cycle later; RESULT_WORDS+1 cycles total, then DONE.
- DONE: Done=1, Timeout held; Busy=0. Go=1 -> clears Done/Timeout, CLEAR next cycle.
- Res_Data holds last value when Res_Valid=0.

Decomposition:
- Package run_harness_pkg: state enum (IDLE, CLEAR, LOAD, START, RUN, READ, DONE), width helper constants.
- Sub-module run_timer: TW-bit counter with clear/enable/terminal-count, used for START_HOLD and TIMEOUT.

Test Plan:
- Reset mid-CLEAR (addr 40) -> next edge all outputs 0, state IDLE, no further Mem_WrEn.
- Go; preload {1:03, 2:ff, 3:ff, 4:fb} Last on 4 -> 256 zero writes, then 4 writes in order, Start high 2 cycles then low.
- Core model acks 20 cycles after Start fall, memory 5..8 = {12,34,56,78} -> Res_Valid 4 cycles, Idx 0..3, Data 12,34,56,78; Done=1, Timeout=0.
- TIMEOUT=50, no Ack -> Done=1, Timeout=1 exactly 50 cycles after Start fall; no Mem_RdEn.
- Preload beat at addr 300 with AW=9, DEPTH=256, plus Ld_Valid gaps -> beat accepted, no write, stall honoured.
- RESULT_BASE=254, RESULT_WORDS=4 -> reads at 254,255,0,1; Go during RUN ignored; Go in DONE restarts with Done cleared.
